// File: rtl/sirius_beta_pkg.sv
// sirius_beta_pkg
// Shared types and constants for the slave (beta) lane EX->MEM result buffer.
//   BETA_DATA_W  : width of PC and result fields
//   BETA_REG_AW  : GPR address width
//   EXC_OV       : default ExcCode for arithmetic overflow
//   beta_entry_t : one buffered EX result
package sirius_beta_pkg;

  localparam int          BETA_DATA_W = 32;
  localparam int          BETA_REG_AW = 5;
  localparam logic [4:0]  EXC_OV      = 5'h0c;

  typedef struct packed {
    logic [BETA_DATA_W-1:0] pc;
    logic [BETA_DATA_W-1:0] result;
    logic                   wen;
    logic [BETA_REG_AW-1:0] waddr;
    logic                   exc;
    logic [4:0]             exc_code;
  } beta_entry_t;

endpackage

// File: rtl/ex_beta_result_buf_if.sv
// ex_beta_result_buf_if
// Valid/ready bundle between the slave ALU, the result buffer and the MEM stage.
//   in_*  : ALU -> buffer (in_ready flows back)
//   out_* : buffer -> MEM (out_ready flows back)
// Modports: slave = the buffer, master = the surrounding pipeline.
interface ex_beta_result_buf_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_pc;
  logic [DATA_W-1:0] in_result;
  logic              in_overflow;
  logic              in_wen;
  logic [REG_AW-1:0] in_waddr;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_pc;
  logic [DATA_W-1:0] out_result;
  logic              out_wen;
  logic [REG_AW-1:0] out_waddr;
  logic              out_exc;
  logic [4:0]        out_exc_code;

  modport slave (
    input  in_valid, in_pc, in_result, in_overflow, in_wen, in_waddr, out_ready,
    output in_ready, out_valid, out_pc, out_result, out_wen, out_waddr, out_exc, out_exc_code
  );

  modport master (
    output in_valid, in_pc, in_result, in_overflow, in_wen, in_waddr, out_ready,
    input  in_ready, out_valid, out_pc, out_result, out_wen, out_waddr, out_exc, out_exc_code
  );
endinterface

// File: rtl/beta_skid_fifo2.sv
// beta_skid_fifo2
// Two-entry valid/ready FIFO of beta_entry_t with synchronous flush.
// in_ready depends only on registered occupancy, so there is no path from out_ready.
// Ports: clk, rst (async active-low), flush, in_valid/in_ready/in_data,
//        out_valid/out_ready/out_data.
// Macro SIRIUS_BETA_FWD_EN: also exports both slots, per-slot valid and the tail
// pointer so the top can do a forwarding lookup.
module beta_skid_fifo2
  import sirius_beta_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  beta_entry_t in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output beta_entry_t out_data
`ifdef SIRIUS_BETA_FWD_EN
  ,
  output beta_entry_t slot_data [2],
  output logic [1:0]  slot_vld,
  output logic        tail_ptr
`endif
);

  beta_entry_t mem [2];
  logic        head;
  logic        tail;
  logic [1:0]  count;
  logic        push;
  logic        pop;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready;
  assign out_data  = mem[head];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      head   <= 1'b0;
      tail   <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      head  <= 1'b0;
      tail  <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) begin
        mem[tail] <= in_data;
        tail      <= ~tail;
      end
      if (pop) head <= ~head;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

`ifdef SIRIUS_BETA_FWD_EN
  // With one entry only the head slot is live; with two both are.
  assign slot_data[0] = mem[0];
  assign slot_data[1] = mem[1];
  assign slot_vld[0]  = (count == 2'd2) | ((count == 2'd1) & (head == 1'b0));
  assign slot_vld[1]  = (count == 2'd2) | ((count == 2'd1) & (head == 1'b1));
  assign tail_ptr     = tail;
`endif

endmodule

// File: rtl/ex_beta_result_buf.sv
// ex_beta_result_buf
// EX->MEM result buffer for the slave ALU lane. Captures the ALU result and
// turns an overflow into a precise Ov exception (write suppressed, result kept
// for debug), then decouples from MEM back-pressure through a 2-entry skid FIFO.
// Ports: clk, rst (async active-low), flush (sync), bus (slave modport of
//        ex_beta_result_buf_if carrying in_* and out_*).
// Macro SIRIUS_BETA_FWD_EN: adds fwd_rs/rt_addr inputs and fwd_rs/rt_hit/data
// outputs, a combinational lookup over the buffered entries (youngest wins).
module ex_beta_result_buf
  import sirius_beta_pkg::*;
#(
  parameter int         DATA_W      = BETA_DATA_W,
  parameter int         REG_AW      = BETA_REG_AW,
  parameter logic [4:0] EXC_OV_CODE = EXC_OV
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  ex_beta_result_buf_if.slave   bus
`ifdef SIRIUS_BETA_FWD_EN
  ,
  input  logic [REG_AW-1:0]     fwd_rs_addr,
  input  logic [REG_AW-1:0]     fwd_rt_addr,
  output logic                  fwd_rs_hit,
  output logic                  fwd_rt_hit,
  output logic [DATA_W-1:0]     fwd_rs_data,
  output logic [DATA_W-1:0]     fwd_rt_data
`endif
);

  logic [DATA_W-1:0] in_pc_w;
  logic [DATA_W-1:0] in_result_w;
  logic [REG_AW-1:0] in_waddr_w;
  beta_entry_t       in_entry;
  beta_entry_t       head;

  assign in_pc_w     = bus.in_pc;
  assign in_result_w = bus.in_result;
  assign in_waddr_w  = bus.in_waddr;

  always_comb begin
    in_entry          = '0;
    in_entry.pc       = in_pc_w;
    in_entry.result   = in_result_w;
    in_entry.wen      = bus.in_wen & ~bus.in_overflow;
    in_entry.waddr    = in_waddr_w;
    in_entry.exc      = bus.in_overflow;
    in_entry.exc_code = bus.in_overflow ? EXC_OV_CODE : 5'h00;
  end

`ifdef SIRIUS_BETA_FWD_EN
  beta_entry_t slot_data [2];
  logic [1:0]  slot_vld;
  logic        tail_ptr;
`endif

  beta_skid_fifo2 u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (in_entry),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (head)
`ifdef SIRIUS_BETA_FWD_EN
    ,
    .slot_data (slot_data),
    .slot_vld  (slot_vld),
    .tail_ptr  (tail_ptr)
`endif
  );

  assign bus.out_pc       = head.pc;
  assign bus.out_result   = head.result;
  assign bus.out_wen      = head.wen;
  assign bus.out_waddr    = head.waddr;
  assign bus.out_exc      = head.exc;
  assign bus.out_exc_code = head.exc_code;

`ifdef SIRIUS_BETA_FWD_EN
  function automatic logic fwd_match(input beta_entry_t e, input logic v,
                                     input logic [REG_AW-1:0] a);
    return v & e.wen & (e.waddr == a) & (a != '0);
  endfunction

  logic yng;
  logic old;
  // The slot just behind tail is the most recent push.
  assign yng = ~tail_ptr;
  assign old = tail_ptr;

  always_comb begin
    fwd_rs_hit  = 1'b0;
    fwd_rs_data = '0;
    fwd_rt_hit  = 1'b0;
    fwd_rt_data = '0;
    if (!flush) begin
      if (fwd_match(slot_data[yng], slot_vld[yng], fwd_rs_addr)) begin
        fwd_rs_hit  = 1'b1;
        fwd_rs_data = slot_data[yng].result;
      end else if (fwd_match(slot_data[old], slot_vld[old], fwd_rs_addr)) begin
        fwd_rs_hit  = 1'b1;
        fwd_rs_data = slot_data[old].result;
      end
      if (fwd_match(slot_data[yng], slot_vld[yng], fwd_rt_addr)) begin
        fwd_rt_hit  = 1'b1;
        fwd_rt_data = slot_data[yng].result;
      end else if (fwd_match(slot_data[old], slot_vld[old], fwd_rt_addr)) begin
        fwd_rt_hit  = 1'b1;
        fwd_rt_data = slot_data[old].result;
      end
    end
  end
`endif

endmodule
